inst_fetch: RTL and testbench

Instruction-fetch stage directly upstream of the control decoder in the MIPS core. It holds the PC and fetches one instruction per execution from a latency-variable instruction memory using a request/response handshake. It presents OpCode/Funct/instr to the decoder and computes the next PC from the decoder's PCSrc/Branch and the ALU Zero flag when the core retires the current instruction.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/next_pc_calc.sv | 36 +++
 rtl/inst_fetch.sv | 85 ++++++++
 tb/tb_inst_fetch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core constants, PCSrc encodings and fetch FSM states
package mips_pkg;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_JUMP = 2'b01;
  localparam logic [1:0] PCSRC_JR   = 2'b10;
  localparam logic [1:0] PCSRC_RSVD = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    EXEC  = 2'd3
  } fetchState_t;

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC selection for sequential, branch, jump and jr flow
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic [1:0]  PCSrc,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] branchOffset;

  assign branchOffset = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    next_pc  = pc_plus4;
    misalign = 1'b0;
    case (PCSrc)
      PCSRC_SEQ: begin
        if (Branch && Zero) next_pc = pc_plus4 + branchOffset;
      end
      PCSRC_JUMP: next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      PCSRC_JR: begin
        // Low bits are dropped so fetch stays word aligned; the fault is flagged instead.
        next_pc  = {jr_target[31:2], 2'b00};
        misalign = |jr_target[1:0];
      end
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: PC register, imem handshake FSM, decoder fields
module inst_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        retire,
  input  logic [1:0]  PCSrc,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] jr_target,
  output logic        pc_misalign
);

  fetchState_t state, stateNext;
  logic [31:0] nextPc;
  logic        jrMisalign;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign OpCode    = instr[31:26];
  assign Funct     = instr[5:0];

  next_pc_calc u_next_pc_calc (
    .pc_plus4  (pc_plus4),
    .instr     (instr),
    .PCSrc     (PCSrc),
    .Branch    (Branch),
    .Zero      (Zero),
    .jr_target (jr_target),
    .next_pc   (nextPc),
    .misalign  (jrMisalign)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      pc_misalign <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == WAIT && imem_rvalid) instr <= imem_rdata;
      if (state == EXEC && retire) begin
        pc <= nextPc;
        if (jrMisalign) pc_misalign <= 1'b1;
      end
    end
  end

  always_comb begin
    stateNext   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      IDLE:  stateNext = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) stateNext = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) stateNext = EXEC;
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (retire) stateNext = FETCH;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch with a reference next-PC model
module tb_inst_fetch;
  import mips_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        retire;
  logic [1:0]  PCSrc;
  logic        Branch;
  logic        Zero;
  logic [31:0] jr_target;
  logic        pc_misalign;

  int nAsserts = 0;
  int nFails   = 0;
  logic [31:0] expPc;
  logic        expMis;
  logic [31:0] curWord;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .OpCode      (OpCode),
    .Funct       (Funct),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .retire      (retire),
    .PCSrc       (PCSrc),
    .Branch      (Branch),
    .Zero        (Zero),
    .jr_target   (jr_target),
    .pc_misalign (pc_misalign)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference next PC from the architectural rules, using signed integer arithmetic.
  function automatic logic [31:0] refNext(input logic [31:0] curPc, input logic [31:0] word,
                                          input logic [1:0] src, input logic br, input logic z,
                                          input logic [31:0] jr);
    logic [31:0] seqPc;
    int          off16;
    seqPc = curPc + 32'd4;
    off16 = int'($signed(word[15:0]));
    case (src)
      2'd0:    return (br && z) ? seqPc + 32'(off16 * 4) : seqPc;
      2'd1:    return (seqPc & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
      2'd2:    return jr & 32'hFFFF_FFFC;
      default: return seqPc;
    endcase
  endfunction

  // noise: 0 quiet, 1 random spurious rvalid/retire, 2 always spurious
  task automatic fetchWord(input logic [31:0] word, input int rdyDly, input int rvDly, input int noise);
    int budget;
    budget = 0;
    while (!imem_req && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check1("req_seen", imem_req, 1'b1);
    check("fetch_addr", imem_addr, expPc);
    check1("fetch_invalid", instr_valid, 1'b0);
    for (int i = 0; i < rdyDly; i++) begin
      imem_ready  = 1'b0;
      imem_rvalid = (noise == 2) ? 1'b1 : (noise == 1) ? 1'($urandom) : 1'b0;
      imem_rdata  = $urandom;
      @(negedge clk);
      check("stall_addr", imem_addr, expPc);
      check1("stall_req", imem_req, 1'b1);
    end
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    @(negedge clk);
    imem_ready = 1'b0;
    check1("wait_req", imem_req, 1'b0);
    check1("wait_invalid", instr_valid, 1'b0);
    for (int i = 0; i < rvDly; i++) begin
      retire = (noise == 2) ? 1'b1 : (noise == 1) ? 1'($urandom) : 1'b0;
      @(negedge clk);
      check1("wait_hold", instr_valid, 1'b0);
      check1("wait_noreq", imem_req, 1'b0);
    end
    retire      = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    curWord     = word;
    check1("exec_valid", instr_valid, 1'b1);
    check("instr", instr, word);
    check("opcode", {26'b0, OpCode}, word >> 26);
    check("funct", {26'b0, Funct}, word & 32'h3F);
    check("pc", pc, expPc);
    check("pc_plus4", pc_plus4, expPc + 32'd4);
  endtask

  task automatic retireWith(input logic [1:0] src, input logic br, input logic z,
                            input logic [31:0] jr, input int holdDly);
    logic [31:0] nxt;
    for (int i = 0; i < holdDly; i++) begin
      @(negedge clk);
      check1("exec_hold", instr_valid, 1'b1);
    end
    nxt = refNext(expPc, curWord, src, br, z, jr);
    if (src == 2'd2 && (jr % 4) != 0) expMis = 1'b1;
    PCSrc     = src;
    Branch    = br;
    Zero      = z;
    jr_target = jr;
    retire    = 1'b1;
    @(negedge clk);
    retire    = 1'b0;
    PCSrc     = 2'($urandom);
    Branch    = 1'($urandom);
    Zero      = 1'($urandom);
    jr_target = $urandom;
    expPc     = nxt;
    check1("retire_invalid", instr_valid, 1'b0);
    check("next_pc", pc, expPc);
    check1("misalign", pc_misalign, expMis);
    check("opcode_hold", {26'b0, OpCode}, curWord >> 26);
  endtask

  initial begin
    logic [31:0] w;
    logic [1:0]  s;
    reset       = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    retire      = 1'b0;
    PCSrc       = 2'b00;
    Branch      = 1'b0;
    Zero        = 1'b0;
    jr_target   = 32'h0;
    expPc       = RST_PC;
    expMis      = 1'b0;
    curWord     = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, RST_PC);
    check("rst_instr", instr, 32'h0);
    check1("rst_valid", instr_valid, 1'b0);
    check1("rst_req", imem_req, 1'b0);
    check1("rst_mis", pc_misalign, 1'b0);
    reset = 1'b1;

    fetchWord(32'h2008_0005, 0, 0, 0);
    check("addi_opcode", {26'b0, OpCode}, 32'h08);
    retireWith(2'd0, 1'b0, 1'b0, 32'h0, 0);
    fetchWord(32'h0109_5020, 0, 1, 0);
    retireWith(2'd0, 1'b0, 1'b1, 32'h0, 0);
    fetchWord(32'h1000_FFFF, 1, 0, 0);
    retireWith(2'd0, 1'b1, 1'b1, 32'h0, 1);
    check("beq_taken", pc, 32'h0000_0008);
    fetchWord(32'h1000_FFFF, 0, 2, 0);
    retireWith(2'd0, 1'b1, 1'b0, 32'h0, 0);
    check("beq_not_taken", pc, 32'h0000_000C);
    fetchWord(32'h0000_0008, 0, 0, 0);
    retireWith(2'd2, 1'b0, 1'b0, 32'h1000_0010, 0);
    fetchWord(32'h0810_0004, 0, 0, 0);
    retireWith(2'd1, 1'b1, 1'b1, 32'h0, 0);
    check("jump_pc", pc, 32'h1040_0010);
    fetchWord(32'h0060_0008, 0, 0, 0);
    retireWith(2'd2, 1'b0, 1'b0, 32'h0000_0103, 0);
    check("jr_pc", pc, 32'h0000_0100);
    check1("jr_mis", pc_misalign, 1'b1);
    for (int i = 0; i < 2; i++) begin
      fetchWord($urandom, 0, 0, 0);
      retireWith(2'd0, 1'b0, 1'b0, 32'h0, 0);
    end
    check1("mis_sticky", pc_misalign, 1'b1);

    fetchWord(32'h03E0_0008, 0, 0, 0);
    retireWith(2'd2, 1'b0, 1'b0, 32'hFFFF_FFFC, 0);
    fetchWord(32'h0000_0000, 0, 0, 0);
    check("wrap_plus4", pc_plus4, 32'h0000_0000);
    retireWith(2'd3, 1'b1, 1'b1, 32'h0, 0);
    check("wrap_pc", pc, 32'h0000_0000);

    fetchWord(32'h8C08_0004, 3, 4, 2);
    retireWith(2'd0, 1'b0, 1'b0, 32'h0, 2);

    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      s = 2'($urandom);
      fetchWord(w, $urandom_range(0, 3), $urandom_range(0, 3), 1);
      retireWith(s, 1'($urandom), 1'($urandom), $urandom, $urandom_range(0, 2));
    end

    // Reset while waiting for read data, with rvalid high through and after release.
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    check1("pre_rst_wait", imem_req, 1'b0);
    reset       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    check("mid_rst_pc", pc, RST_PC);
    check("mid_rst_instr", instr, 32'h0);
    check1("mid_rst_valid", instr_valid, 1'b0);
    check1("mid_rst_req", imem_req, 1'b0);
    check1("mid_rst_mis", pc_misalign, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    imem_rvalid = 1'b0;
    expPc       = RST_PC;
    expMis      = 1'b0;
    check("post_rst_instr", instr, 32'h0);
    check1("post_rst_valid", instr_valid, 1'b0);
    check1("post_rst_req", imem_req, 1'b1);
    check("post_rst_addr", imem_addr, RST_PC);
    fetchWord(32'h2009_0007, 0, 1, 0);
    retireWith(2'd0, 1'b0, 1'b0, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
